regfile_sweep_master: RTL and testbench
=======================================

Name: regfile_sweep_master

Overview:
- Initiator that drives the write and read ports of the 32x32 register file.
- On START it performs a fill-then-verify sweep:
  - writes an arithmetic sequence into every register through the RW/PW/LE port;
  - reads all registers back through both read ports in opposite orders;
  - checks each value, including the R0 hard-zero rule.
- Used as power-up self-test and as the regfile stimulus engine in bring-up benches.

Parameters:
- NREGS, 32, number of registers swept (power of two).
- AW, 5, register address width (log2 NREGS).
- DW, 32, data width.

Ports:
- CLK  in  1  clock; all state updates on posedge.
- RST  in  1  synchronous active-high reset.
- START  in  1  one-cycle request; sampled only in IDLE.
- BASE  in  DW  value for register 0 of the sequence; latched at START acceptance.
- STEP  in  DW  increment between consecutive registers; latched at START acceptance.
- BUSY  out  1  high during WRITE and READ phases.
- DONE  out  1  one-cycle pulse when the sweep completes.
- ERR  out  1  sticky; at least one mismatch in the current or last sweep.
- ERR_COUNT  out  7  number of mismatching read slots (max 2*NREGS = 64).
- FIRST_ERR_ADDR  out  AW  register index of the first mismatch; valid only when ERR=1.
- RW  out  AW  write address to the register file.
- PW  out  DW  write data to the register file.
- LE  out  1  write enable to the register file.
- RA  out  AW  read address, port A.
- RB  out  AW  read address, port B.
- PA  in  DW  read data, port A (combinational from RA).
- PB  in  DW  read data, port B (combinational from RB).

Behaviour:
- Reset:
  - state=IDLE.
  - BUSY=DONE=ERR=LE=0.
  - ERR_COUNT=0, FIRST_ERR_ADDR=0.
  - RW=RA=RB=0, PW=0.
- Output timing: all outputs are registered; regfile port outputs change only on CLK edges.
- IDLE:
  - LE=0, RW=RA=RB=PW=0.
  - START=1 at an edge: latch BASE/STEP, clear ERR/ERR_COUNT/FIRST_ERR_ADDR, idx=0, go to WRITE.
- WRITE, NREGS cycles, idx = 0..NREGS-1:
  - Drive LE=1, RW=idx, PW=BASE+idx*STEP (mod 2^DW).
  - The idx=0 write is issued deliberately; the regfile must discard it.
  - After idx=NREGS-1: idx=0, go to READ.
- PW sequence generation: running accumulator (add STEP per cycle). No multiplier.
- READ, NREGS cycles:
  - LE=0, RA=idx, RB=NREGS-1-idx.
  - Same cycle, compare PA with exp(RA) and PB with exp(RB).
  - exp(r) = 0 if r==0, else BASE+r*STEP mod 2^DW.
  - Port B expected value uses a descending accumulator starting at BASE+(NREGS-1)*STEP.
- Mismatch accounting per READ cycle:
  - Each mismatching port adds 1 to ERR_COUNT; both mismatching adds 2 in one cycle.
  - ERR set on the first mismatch.
  - FIRST_ERR_ADDR captured on the first mismatch only; port A index wins if both mismatch that cycle.
- After READ idx=NREGS-1: go to DONE_ST.
- DONE_ST: DONE=1 for exactly one cycle, BUSY=0, go to IDLE.
- Hold: ERR/ERR_COUNT/FIRST_ERR_ADDR hold until the next accepted START.
- Latency: START accepted at edge E0 → BUSY=1 for cycles E0..E(2*NREGS); DONE high in the cycle after edge E(2*NREGS), i.e. 64 cycles of BUSY then DONE.
- START while BUSY or DONE_ST: ignored; no restart and no effect on counters.
- RST mid-sweep: returns to IDLE at that edge with LE=0 and BUSY=0 immediately; partial writes already in the regfile remain.
- Wrap-around: PW and expected values wrap modulo 2^DW, with no saturation or flag.
- ERR_COUNT cannot overflow; 7 bits covers 64.

Decomposition:
- Shared package regfile_pkg:
  - NREGS, AW, DW constants;
  - state enum {IDLE, WRITE, READ, DONE_ST};
  - ZERO_REG index constant (0).
- One natural sub-module, seq_accum:
  - loadable DW-bit accumulator with add/subtract STEP;
  - instantiated three times: write data, port A expected, port B expected.

Test Plan:
- Clean sweep: BASE=20, STEP=1, correct regfile → PW sequence 20..51 on RW 0..31; DONE 64 cycles after START; ERR=0, ERR_COUNT=0; regfile R0 reads 0, R5 reads 25.
- R0 protection: after sweep, RA=0 → expected 0. A faulty regfile model that honours the write to R0 → ERR=1, ERR_COUNT=2 (idx0 port A, idx31 port B), FIRST_ERR_ADDR=0.
- Stuck-bit fault: regfile model forces bit0 of R5 to 0, BASE=0, STEP=1 → ERR_COUNT=2 (port A at idx5, port B at idx26), FIRST_ERR_ADDR=5.
- Wrap: BASE=32'hFFFF_FFF0, STEP=1 → PW for RW=16 is 0, RW=31 is 32'h0000_000F; ERR=0.
- START while busy: second START pulse at cycle 10 → no restart; DONE still at cycle 64; ERR_COUNT unchanged.
- Reset mid-write: RST at WRITE cycle 10 → next cycle BUSY=0, LE=0, DONE never pulses; a new START then completes normally with ERR=0.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared constants and state encoding for the register-file sweep master.
package regfile_pkg;

  localparam int NREGS = 32;
  localparam int AW    = 5;
  localparam int DW    = 32;

  localparam logic [AW-1:0] ZERO_REG = 5'd0;
  localparam logic [AW-1:0] LAST_IDX = 5'd31;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WRITE   = 2'd1,
    READ    = 2'd2,
    DONE_ST = 2'd3
  } state_t;

endpackage

// File: rtl/regfile_sweep_master_if.sv
// Register-file port bundle: one write port (RW/PW/LE) and two combinational read ports.
interface regfile_sweep_master_if;
  import regfile_pkg::*;

  logic [AW-1:0] RW;
  logic [DW-1:0] PW;
  logic          LE;
  logic [AW-1:0] RA;
  logic [AW-1:0] RB;
  logic [DW-1:0] PA;
  logic [DW-1:0] PB;

  modport master (output RW, PW, LE, RA, RB, input  PA, PB);
  modport slave  (input  RW, PW, LE, RA, RB, output PA, PB);
endinterface

// File: rtl/regfile_sweep_master_seq_accum.sv
// Loadable accumulator stepping by +/-STEP each enabled cycle; load has priority.
module seq_accum
  import regfile_pkg::*;
(
  input  logic          CLK,
  input  logic          RST,
  input  logic          load,
  input  logic [DW-1:0] load_val,
  input  logic          en,
  input  logic          sub,
  input  logic [DW-1:0] step,
  output logic [DW-1:0] acc
);

  logic [DW-1:0] acc_r;

  // accumulator register, wraps modulo 2^DW
  always_ff @(posedge CLK) begin
    if (RST) begin
      acc_r <= {DW{1'b0}};
    end else if (load) begin
      acc_r <= load_val;
    end else if (en) begin
      acc_r <= sub ? (acc_r - step) : (acc_r + step);
    end else begin
      acc_r <= acc_r;
    end
  end

  assign acc = acc_r;

endmodule

// File: rtl/regfile_sweep_master.sv
// Fill-then-verify sweep of the 32x32 register file: writes BASE+i*STEP to every
// register, reads back on both ports in opposite orders and counts mismatches.
module regfile_sweep_master
  import regfile_pkg::*;
(
  input  logic          CLK,
  input  logic          RST,
  input  logic          START,
  input  logic [DW-1:0] BASE,
  input  logic [DW-1:0] STEP,
  output logic          BUSY,
  output logic          DONE,
  output logic          ERR,
  output logic [6:0]    ERR_COUNT,
  output logic [AW-1:0] FIRST_ERR_ADDR,
  regfile_sweep_master_if.master rf
);

  state_t        state_r;
  logic [AW-1:0] idx_r;
  logic [DW-1:0] step_r;
  logic          busy_r, done_r, err_r, le_r;
  logic [6:0]    err_count_r;
  logic [AW-1:0] first_err_r, rw_r, ra_r, rb_r;

  logic          wr_load_s, wr_en_s, a_load_s, a_en_s, b_load_s, b_en_s;
  logic [DW-1:0] wr_load_val_s, wr_acc_s, acc_a_s, acc_b_s, exp_a_s, exp_b_s;
  logic          mis_a_s, mis_b_s;

  // accumulator control: write data runs during WRITE; its final value seeds port B
  always_comb begin
    wr_load_s     = 1'b0;
    wr_load_val_s = {DW{1'b0}};
    wr_en_s       = 1'b0;
    a_load_s      = 1'b0;
    a_en_s        = 1'b0;
    b_load_s      = 1'b0;
    b_en_s        = 1'b0;
    case (state_r)
      IDLE: begin
        if (START) begin
          wr_load_s     = 1'b1;
          wr_load_val_s = BASE;
          a_load_s      = 1'b1;
        end else begin
          wr_load_s = 1'b0;
        end
      end
      WRITE: begin
        if (idx_r == LAST_IDX) begin
          wr_load_s = 1'b1;
          b_load_s  = 1'b1;
        end else begin
          wr_en_s = 1'b1;
        end
      end
      READ: begin
        a_en_s = 1'b1;
        b_en_s = 1'b1;
      end
      default: begin
        wr_load_s = 1'b0;
      end
    endcase
  end

  seq_accum u_wr (.CLK(CLK), .RST(RST), .load(wr_load_s), .load_val(wr_load_val_s),
                  .en(wr_en_s), .sub(1'b0), .step(step_r), .acc(wr_acc_s));
  seq_accum u_ea (.CLK(CLK), .RST(RST), .load(a_load_s), .load_val(BASE),
                  .en(a_en_s), .sub(1'b0), .step(step_r), .acc(acc_a_s));
  seq_accum u_eb (.CLK(CLK), .RST(RST), .load(b_load_s), .load_val(wr_acc_s),
                  .en(b_en_s), .sub(1'b1), .step(step_r), .acc(acc_b_s));

  // expected read data, R0 always reads as zero
  always_comb begin
    exp_a_s = (ra_r == ZERO_REG) ? {DW{1'b0}} : acc_a_s;
    exp_b_s = (rb_r == ZERO_REG) ? {DW{1'b0}} : acc_b_s;
    mis_a_s = (rf.PA != exp_a_s);
    mis_b_s = (rf.PB != exp_b_s);
  end

  // sweep sequencer with registered outputs
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_r     <= IDLE;
      idx_r       <= 5'd0;
      step_r      <= {DW{1'b0}};
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      err_r       <= 1'b0;
      err_count_r <= 7'd0;
      first_err_r <= 5'd0;
      le_r        <= 1'b0;
      rw_r        <= 5'd0;
      ra_r        <= 5'd0;
      rb_r        <= 5'd0;
    end else begin
      case (state_r)
        IDLE: begin
          done_r <= 1'b0;
          le_r   <= START;
          busy_r <= START;
          rw_r   <= 5'd0;
          ra_r   <= 5'd0;
          rb_r   <= 5'd0;
          idx_r  <= 5'd0;
          if (START) begin
            state_r     <= WRITE;
            step_r      <= STEP;
            err_r       <= 1'b0;
            err_count_r <= 7'd0;
            first_err_r <= 5'd0;
          end else begin
            state_r <= IDLE;
          end
        end
        WRITE: begin
          if (idx_r == LAST_IDX) begin
            state_r <= READ;
            idx_r   <= 5'd0;
            le_r    <= 1'b0;
            rw_r    <= 5'd0;
            ra_r    <= 5'd0;
            rb_r    <= LAST_IDX;
          end else begin
            idx_r <= idx_r + 5'd1;
            rw_r  <= idx_r + 5'd1;
          end
        end
        READ: begin
          err_count_r <= err_count_r + {6'd0, mis_a_s} + {6'd0, mis_b_s};
          // port A index wins when both ports miss in the same cycle
          if (!err_r && (mis_a_s || mis_b_s)) begin
            err_r       <= 1'b1;
            first_err_r <= mis_a_s ? ra_r : rb_r;
          end else begin
            err_r <= err_r;
          end
          if (idx_r == LAST_IDX) begin
            state_r <= DONE_ST;
            busy_r  <= 1'b0;
            done_r  <= 1'b1;
            ra_r    <= 5'd0;
            rb_r    <= 5'd0;
            idx_r   <= 5'd0;
          end else begin
            idx_r <= idx_r + 5'd1;
            ra_r  <= idx_r + 5'd1;
            rb_r  <= LAST_IDX - (idx_r + 5'd1);
          end
        end
        DONE_ST: begin
          state_r <= IDLE;
          done_r  <= 1'b0;
        end
        default: begin
          state_r <= IDLE;
          busy_r  <= 1'b0;
          done_r  <= 1'b0;
          le_r    <= 1'b0;
        end
      endcase
    end
  end

  assign BUSY           = busy_r;
  assign DONE           = done_r;
  assign ERR            = err_r;
  assign ERR_COUNT      = err_count_r;
  assign FIRST_ERR_ADDR = first_err_r;
  assign rf.LE          = le_r;
  assign rf.RW          = rw_r;
  assign rf.PW          = wr_acc_s;
  assign rf.RA          = ra_r;
  assign rf.RB          = rb_r;

endmodule

// File: tb/tb_regfile_sweep_master.sv
// Directed bench: behavioural regfile with injectable faults, table of sweeps plus hand sequences.
module tb_regfile_sweep_master;
  import regfile_pkg::*;

  logic          CLK = 1'b0;
  logic          RST = 1'b1;
  logic          START = 1'b0;
  logic [DW-1:0] BASE = 32'd0;
  logic [DW-1:0] STEP = 32'd0;
  logic          BUSY, DONE, ERR;
  logic [6:0]    ERR_COUNT;
  logic [AW-1:0] FIRST_ERR_ADDR;

  regfile_sweep_master_if rf_if();

  regfile_sweep_master dut (
    .CLK(CLK), .RST(RST), .START(START), .BASE(BASE), .STEP(STEP),
    .BUSY(BUSY), .DONE(DONE), .ERR(ERR), .ERR_COUNT(ERR_COUNT),
    .FIRST_ERR_ADDR(FIRST_ERR_ADDR), .rf(rf_if)
  );

  always #5 CLK = ~CLK;

  logic [31:0] mem [32];
  logic        fault_r0 = 1'b0;
  logic        fault_stuck = 1'b0;
  logic [31:0] pw_cap [32];
  int          checks = 0;
  int          errors = 0;
  int          le_cycles;

  // regfile model; fault_r0 makes R0 writable, fault_stuck clears bit0 of R5
  always @(posedge CLK) begin
    if (rf_if.LE && (rf_if.RW != 5'd0 || fault_r0)) mem[rf_if.RW] <= rf_if.PW;
  end

  function automatic logic [31:0] rd(input logic [4:0] a);
    logic [31:0] v;
    v = (a == 5'd0 && !fault_r0) ? 32'd0 : mem[a];
    if (fault_stuck && a == 5'd5) v[0] = 1'b0;
    return v;
  endfunction

  always_comb begin
    rf_if.PA = rd(rf_if.RA);
    rf_if.PB = rd(rf_if.RB);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // one sweep; extra START pulse at cycle inj (>=0) must be ignored
  task automatic run_sweep(input logic [31:0] b, input logic [31:0] s, input int inj,
                           input logic e_err, input logic [6:0] e_cnt, input logic [4:0] e_first);
    int k, bad;
    for (int i = 0; i < 32; i++) pw_cap[i] = 'x;
    le_cycles = 0;
    @(negedge CLK); BASE = b; STEP = s; START = 1'b1;
    @(negedge CLK); START = 1'b0;
    chk("busy_start", BUSY, 1'b1);
    k = 0;
    while (!DONE && k < 200) begin
      if (rf_if.LE) begin pw_cap[rf_if.RW] = rf_if.PW; le_cycles++; end
      if (k == inj) START = 1'b1;
      if (k == inj + 1) START = 1'b0;
      @(negedge CLK); k++;
    end
    START = 1'b0;
    chk("done_latency", k, DONE ? 64 : -1);
    chk("busy_at_done", BUSY, 1'b0);
    chk("err", ERR, e_err);
    chk("err_count", ERR_COUNT, e_cnt);
    if (e_err) chk("first_err_addr", FIRST_ERR_ADDR, e_first);
    bad = 0;
    for (int i = 0; i < 32; i++) if (pw_cap[i] !== b + i * s) bad++;
    chk("pw_seq_bad", bad, 0);
    chk("le_cycles", le_cycles, 32);
    @(negedge CLK); @(negedge CLK);
    chk("done_pulse_one", DONE, 1'b0);
    chk("err_hold", {ERR, ERR_COUNT}, {e_err, e_cnt});
  endtask

  typedef struct {
    logic [31:0] base;
    logic [31:0] step;
    logic        f_r0;
    logic        f_stuck;
    logic        e_err;
    logic [6:0]  e_cnt;
    logic [4:0]  e_first;
  } vec_t;

  vec_t vecs [7];
  int seen;

  initial begin
    for (int i = 0; i < 32; i++) mem[i] = 32'd0;
    vecs[0] = '{32'd20,         32'd1,          1'b0, 1'b0, 1'b0, 7'd0, 5'd0};
    vecs[1] = '{32'd20,         32'd1,          1'b1, 1'b0, 1'b1, 7'd2, 5'd0};
    vecs[2] = '{32'd0,          32'd1,          1'b0, 1'b1, 1'b1, 7'd2, 5'd5};
    vecs[3] = '{32'hFFFF_FFF0,  32'd1,          1'b0, 1'b0, 1'b0, 7'd0, 5'd0};
    vecs[4] = '{32'd0,          32'd0,          1'b1, 1'b0, 1'b0, 7'd0, 5'd0};
    vecs[5] = '{32'h0000_1234,  32'hFFFF_FFFF,  1'b0, 1'b0, 1'b0, 7'd0, 5'd0};
    vecs[6] = '{32'd1,          32'd2,          1'b0, 1'b1, 1'b1, 7'd2, 5'd5};

    repeat (3) @(negedge CLK);
    RST = 1'b0;
    @(negedge CLK);
    chk("reset_flags", {BUSY, DONE, ERR, rf_if.LE}, 4'd0);
    chk("reset_counts", {ERR_COUNT, FIRST_ERR_ADDR}, 12'd0);
    chk("reset_addrs", {rf_if.RW, rf_if.RA, rf_if.RB}, 15'd0);
    chk("reset_pw", rf_if.PW, 32'd0);

    for (int v = 0; v < 7; v++) begin
      fault_r0 = vecs[v].f_r0;
      fault_stuck = vecs[v].f_stuck;
      run_sweep(vecs[v].base, vecs[v].step, -10, vecs[v].e_err, vecs[v].e_cnt, vecs[v].e_first);
      if (v == 0) begin
        chk("r5_content", mem[5], 32'd25);
        chk("r0_read", rd(5'd0), 32'd0);
      end
      if (v == 3) begin
        chk("wrap_pw16", pw_cap[16], 32'd0);
        chk("wrap_pw31", pw_cap[31], 32'h0000_000F);
      end
    end

    // second START mid-sweep must not restart or disturb the counters
    fault_r0 = 1'b0;
    fault_stuck = 1'b1;
    run_sweep(32'd0, 32'd1, 10, 1'b1, 7'd2, 5'd5);

    // synchronous reset during WRITE, then a clean sweep
    fault_stuck = 1'b0;
    @(negedge CLK); BASE = 32'd0; STEP = 32'd1; START = 1'b1;
    @(negedge CLK); START = 1'b0;
    repeat (10) @(negedge CLK);
    chk("mid_write_le", rf_if.LE, 1'b1);
    RST = 1'b1;
    @(negedge CLK); RST = 1'b0;
    chk("rst_busy", BUSY, 1'b0);
    chk("rst_le", rf_if.LE, 1'b0);
    seen = 0;
    repeat (100) begin
      @(negedge CLK);
      if (DONE) seen = 1;
    end
    chk("no_done_after_rst", seen, 0);
    run_sweep(32'd7, 32'd3, -10, 1'b0, 7'd0, 5'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
